// File: rtl/control_if.sv
// ----------------------------------------------------------------------------
// control_if
//
// Bundles the decoder's instruction input, the ALU-zero feedback and every
// datapath control output into one interface.
//
// Modports:
//   master - datapath side: drives instruction/alu_zero, receives controls
//   slave  - decoder side (module control): receives instruction/alu_zero,
//            drives controls
//
// Signals:
//   instruction[31:0]  current instruction word
//   alu_zero           ALU result == 0 for the current instruction
//   reg_write          register-file write enable
//   alu_src            ALU operand B select (0 register, 1 imm16)
//   alu_op[2:0]        ALU operation code
//   addr_a/addr_b[4:0] register read port addresses
//   addr_in[4:0]       register write address
//   shamt[4:0]         shift amount (non-zero only for sll/srl)
//   imm16[15:0]        instruction[15:0]
//   addr26[25:0]       instruction[25:0]
//   imm_zext           zero-extend imm16 instead of sign-extend
//   is_jump/is_branch  unconditional / conditional control transfer
//   cond_sel[1:0]      00 none, 01 rs==rt, 10 rs!=rt, 11 z-flag condition
//   tgt_sel[1:0]       00 PC-relative, 01 absolute, 10 port A, 11 memory
//   link               write PC+4 to addr_in
//   mem_read/mem_write data-memory strobes
//   z_ok               the z-conditional instruction's condition holds
//   illegal            undecodable instruction
// ----------------------------------------------------------------------------
interface control_if;
    logic [31:0] instruction;
    logic        alu_zero;
    logic        reg_write;
    logic        alu_src;
    logic [2:0]  alu_op;
    logic [4:0]  addr_a;
    logic [4:0]  addr_b;
    logic [4:0]  addr_in;
    logic [4:0]  shamt;
    logic [15:0] imm16;
    logic [25:0] addr26;
    logic        imm_zext;
    logic        is_jump;
    logic        is_branch;
    logic [1:0]  cond_sel;
    logic [1:0]  tgt_sel;
    logic        link;
    logic        mem_read;
    logic        mem_write;
    logic        z_ok;
    logic        illegal;

    modport master (
        output instruction, alu_zero,
        input  reg_write, alu_src, alu_op, addr_a, addr_b, addr_in, shamt,
               imm16, addr26, imm_zext, is_jump, is_branch, cond_sel,
               tgt_sel, link, mem_read, mem_write, z_ok, illegal
    );

    modport slave (
        input  instruction, alu_zero,
        output reg_write, alu_src, alu_op, addr_a, addr_b, addr_in, shamt,
               imm16, addr26, imm_zext, is_jump, is_branch, cond_sel,
               tgt_sel, link, mem_read, mem_write, z_ok, illegal
    );
endinterface

// File: rtl/control.sv
// ----------------------------------------------------------------------------
// control
//
// Single-cycle MIPS-variant instruction decoder. Every output except z_ok is
// a pure combinational function of the instruction word. The only state is
// the one-bit zero flag z, loaded from alu_zero on flag-setting instructions
// (R-type ALU ops, shifts, addi, andi, ori) and consumed by the z-conditional
// branches, which see the value from before the current clock edge.
//
// Optional feature macro: CONTROL_ZFLAG_EN
//   defined     - z register and z-conditional branches are implemented
//   not defined - z-conditional encodings decode as illegal, z_ok is 0,
//                 clk/reset/alu_zero are unused
//
// Ports:
//   clk    clock, only the z flag is clocked
//   reset  asynchronous active-high, clears z
//   bus    control_if.slave, instruction in, all decoded controls out
// ----------------------------------------------------------------------------
module control (
    input  logic      clk,
    input  logic      reset,
    control_if.slave  bus
);

    // ALU operation codes
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_NOR = 3'd4;
    localparam logic [2:0] OP_SLT = 3'd5;
    localparam logic [2:0] OP_SLL = 3'd6;
    localparam logic [2:0] OP_SRL = 3'd7;

    localparam logic ALU_SRC_REG   = 1'b0;
    localparam logic ALU_SRC_IMM16 = 1'b1;

    localparam logic [1:0] COND_NONE = 2'b00;
    localparam logic [1:0] COND_EQ   = 2'b01;
    localparam logic [1:0] COND_NE   = 2'b10;
    localparam logic [1:0] COND_Z    = 2'b11;

    localparam logic [1:0] TGT_PCREL = 2'b00;
    localparam logic [1:0] TGT_ABS   = 2'b01;
    localparam logic [1:0] TGT_REG   = 2'b10;
    localparam logic [1:0] TGT_MEM   = 2'b11;

    localparam logic [4:0] LINK_REG = 5'd31;

    // Primary opcodes
    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_JAL   = 6'h03;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_BNE   = 6'h05;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_JM    = 6'h12;
    localparam logic [5:0] OPC_JALM  = 6'h13;
    localparam logic [5:0] OPC_BMZ   = 6'h14;
    localparam logic [5:0] OPC_BMN   = 6'h15;
    localparam logic [5:0] OPC_BALMZ = 6'h16;
    localparam logic [5:0] OPC_BALMN = 6'h17;
    localparam logic [5:0] OPC_BZ    = 6'h18;
    localparam logic [5:0] OPC_BN    = 6'h19;
    localparam logic [5:0] OPC_BALZ  = 6'h1A;
    localparam logic [5:0] OPC_BALN  = 6'h1B;
    localparam logic [5:0] OPC_JPC   = 6'h1E;
    localparam logic [5:0] OPC_JALPC = 6'h1F;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;
    localparam logic [5:0] OPC_BEQAL = 6'h2C;
    localparam logic [5:0] OPC_BNEAL = 6'h2D;

    // R-type function codes
    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_JR    = 6'h08;
    localparam logic [5:0] F_JALR  = 6'h09;
    localparam logic [5:0] F_BRZ   = 6'h14;
    localparam logic [5:0] F_BRN   = 6'h15;
    localparam logic [5:0] F_BALRZ = 6'h16;
    localparam logic [5:0] F_BALRN = 6'h17;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;

    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] sh;
    logic [5:0] funct;

    assign op    = bus.instruction[31:26];
    assign rs    = bus.instruction[25:21];
    assign rt    = bus.instruction[20:16];
    assign rd    = bus.instruction[15:11];
    assign sh    = bus.instruction[10:6];
    assign funct = bus.instruction[5:0];

    assign bus.imm16  = bus.instruction[15:0];
    assign bus.addr26 = bus.instruction[25:0];

    logic       reg_write;
    logic       alu_src;
    logic [2:0] alu_op;
    logic [4:0] addr_a;
    logic [4:0] addr_b;
    logic [4:0] addr_in;
    logic [4:0] shamt;
    logic       imm_zext;
    logic       is_jump;
    logic       is_branch;
    logic [1:0] cond_sel;
    logic [1:0] tgt_sel;
    logic       link;
    logic       mem_read;
    logic       mem_write;
    logic       illegal;
    logic       flag_set;   // instruction loads z from alu_zero
    logic       z_var;      // z-conditional, taken when z==1
    logic       n_var;      // z-conditional, taken when z==0

    always_comb begin
        reg_write = 1'b0;
        alu_src   = ALU_SRC_REG;
        alu_op    = OP_ADD;
        addr_a    = rs;
        addr_b    = rt;
        addr_in   = 5'd0;
        shamt     = 5'd0;
        imm_zext  = 1'b0;
        is_jump   = 1'b0;
        is_branch = 1'b0;
        cond_sel  = COND_NONE;
        tgt_sel   = TGT_PCREL;
        link      = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        illegal   = 1'b0;
        flag_set  = 1'b0;
        z_var     = 1'b0;
        n_var     = 1'b0;

        case (op)
            OPC_RTYPE: begin
                case (funct)
                    F_ADD, F_SUB, F_AND, F_OR, F_NOR, F_SLT: begin
                        reg_write = 1'b1;
                        addr_in   = rd;
                        flag_set  = 1'b1;
                        case (funct)
                            F_SUB:   alu_op = OP_SUB;
                            F_AND:   alu_op = OP_AND;
                            F_OR:    alu_op = OP_OR;
                            F_NOR:   alu_op = OP_NOR;
                            F_SLT:   alu_op = OP_SLT;
                            default: alu_op = OP_ADD;
                        endcase
                    end
                    F_SLL, F_SRL: begin
                        // The shifted operand arrives on port A
                        addr_a    = rt;
                        shamt     = sh;
                        addr_in   = rd;
                        reg_write = 1'b1;
                        flag_set  = 1'b1;
                        alu_op    = (funct == F_SLL) ? OP_SLL : OP_SRL;
                    end
                    F_JR, F_JALR: begin
                        is_jump = 1'b1;
                        tgt_sel = TGT_REG;
                        if (funct == F_JALR) begin
                            link      = 1'b1;
                            reg_write = 1'b1;
                            addr_in   = rd;
                        end
                    end
`ifdef CONTROL_ZFLAG_EN
                    // funct[0] selects the "n" variant, funct[1] the linking one
                    F_BRZ, F_BRN, F_BALRZ, F_BALRN: begin
                        is_branch = 1'b1;
                        cond_sel  = COND_Z;
                        tgt_sel   = TGT_REG;
                        z_var     = ~funct[0];
                        n_var     = funct[0];
                        if (funct[1]) begin
                            link      = 1'b1;
                            reg_write = 1'b1;
                            addr_in   = rd;
                        end
                    end
`endif
                    default: illegal = 1'b1;
                endcase
            end
            OPC_ADDI, OPC_ANDI, OPC_ORI: begin
                alu_src   = ALU_SRC_IMM16;
                addr_in   = rt;
                reg_write = 1'b1;
                flag_set  = 1'b1;
                imm_zext  = (op != OPC_ADDI);
                case (op)
                    OPC_ANDI: alu_op = OP_AND;
                    OPC_ORI:  alu_op = OP_OR;
                    default:  alu_op = OP_ADD;
                endcase
            end
            OPC_LW: begin
                alu_src   = ALU_SRC_IMM16;
                mem_read  = 1'b1;
                reg_write = 1'b1;
                addr_in   = rt;
            end
            OPC_SW: begin
                // Port A carries store data, port B the base address
                addr_a    = rt;
                addr_b    = rs;
                alu_src   = ALU_SRC_IMM16;
                mem_write = 1'b1;
            end
            OPC_BEQ, OPC_BNE, OPC_BEQAL, OPC_BNEAL: begin
                // Equality comes from the datapath comparator; the ALU
                // result is not used for these branches.
                is_branch = 1'b1;
                tgt_sel   = TGT_PCREL;
                alu_op    = OP_SLT;
                cond_sel  = op[0] ? COND_NE : COND_EQ;
                if (op[3]) begin
                    link      = 1'b1;
                    reg_write = 1'b1;
                    addr_in   = LINK_REG;
                end
            end
            OPC_J, OPC_JAL: begin
                is_jump = 1'b1;
                tgt_sel = TGT_ABS;
                if (op[0]) begin
                    link      = 1'b1;
                    reg_write = 1'b1;
                    addr_in   = LINK_REG;
                end
            end
            OPC_JM, OPC_JALM: begin
                is_jump = 1'b1;
                tgt_sel = TGT_MEM;
                alu_src = ALU_SRC_IMM16;
                if (op[0]) begin
                    link      = 1'b1;
                    reg_write = 1'b1;
                    addr_in   = rt;
                end
            end
            OPC_JPC, OPC_JALPC: begin
                is_jump = 1'b1;
                tgt_sel = TGT_PCREL;
                if (op[0]) begin
                    link      = 1'b1;
                    reg_write = 1'b1;
                    addr_in   = rt;
                end
            end
`ifdef CONTROL_ZFLAG_EN
            OPC_BMZ, OPC_BMN, OPC_BALMZ, OPC_BALMN: begin
                is_branch = 1'b1;
                cond_sel  = COND_Z;
                tgt_sel   = TGT_MEM;
                alu_src   = ALU_SRC_IMM16;
                z_var     = ~op[0];
                n_var     = op[0];
                if (op[1]) begin
                    link      = 1'b1;
                    reg_write = 1'b1;
                    addr_in   = rt;
                end
            end
            OPC_BZ, OPC_BN, OPC_BALZ, OPC_BALN: begin
                is_branch = 1'b1;
                cond_sel  = COND_Z;
                tgt_sel   = TGT_ABS;
                z_var     = ~op[0];
                n_var     = op[0];
                if (op[1]) begin
                    link      = 1'b1;
                    reg_write = 1'b1;
                    addr_in   = LINK_REG;
                end
            end
`endif
            default: illegal = 1'b1;
        endcase
    end

    assign bus.reg_write = reg_write;
    assign bus.alu_src   = alu_src;
    assign bus.alu_op    = alu_op;
    assign bus.addr_a    = addr_a;
    assign bus.addr_b    = addr_b;
    assign bus.addr_in   = addr_in;
    assign bus.shamt     = shamt;
    assign bus.imm_zext  = imm_zext;
    assign bus.is_jump   = is_jump;
    assign bus.is_branch = is_branch;
    assign bus.cond_sel  = cond_sel;
    assign bus.tgt_sel   = tgt_sel;
    assign bus.link      = link;
    assign bus.mem_read  = mem_read;
    assign bus.mem_write = mem_write;
    assign bus.illegal   = illegal;

`ifdef CONTROL_ZFLAG_EN
    logic z_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            z_reg <= 1'b0;
        end else if (flag_set) begin
            z_reg <= bus.alu_zero;
        end
    end

    // Uses the registered flag, i.e. the value before the current edge
    assign bus.z_ok = (z_var & z_reg) | (n_var & ~z_reg);
`else
    logic unused_zflag;
    assign unused_zflag = ^{clk, reset, bus.alu_zero, flag_set, z_var, n_var};
    assign bus.z_ok     = 1'b0;
`endif

endmodule

// File: tb/tb_control.sv
// ----------------------------------------------------------------------------
// tb_control
//
// Self-checking bench for the control decoder. Each test task queues
// scoreboard entries (instruction, alu_zero, optional mid-cycle reset pulse
// and the expected decode), then drives them one per clock and compares the
// DUT outputs against the popped expectation. The z-flag scenarios follow
// the CONTROL_ZFLAG_EN build option of the design.
// ----------------------------------------------------------------------------
module tb_control;

    logic clk = 1'b0;
    logic reset;

    control_if cif ();

    control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (cif)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        reg_write;
        logic        alu_src;
        logic [2:0]  alu_op;
        logic [4:0]  addr_a;
        logic [4:0]  addr_b;
        logic [4:0]  addr_in;
        logic [4:0]  shamt;
        logic [15:0] imm16;
        logic [25:0] addr26;
        logic        imm_zext;
        logic        is_jump;
        logic        is_branch;
        logic [1:0]  cond_sel;
        logic [1:0]  tgt_sel;
        logic        link;
        logic        mem_read;
        logic        mem_write;
        logic        illegal;
        logic        z_ok;
    } dec_t;

    typedef struct {
        string       name;
        logic [31:0] ins;
        logic        az;
        logic        pulse;
        dec_t        exp;
    } sb_item_t;

    sb_item_t sb[$];
    int total = 0;
    int bad   = 0;

    function automatic dec_t sample();
        dec_t d;
        d.reg_write = cif.reg_write;
        d.alu_src   = cif.alu_src;
        d.alu_op    = cif.alu_op;
        d.addr_a    = cif.addr_a;
        d.addr_b    = cif.addr_b;
        d.addr_in   = cif.addr_in;
        d.shamt     = cif.shamt;
        d.imm16     = cif.imm16;
        d.addr26    = cif.addr26;
        d.imm_zext  = cif.imm_zext;
        d.is_jump   = cif.is_jump;
        d.is_branch = cif.is_branch;
        d.cond_sel  = cif.cond_sel;
        d.tgt_sel   = cif.tgt_sel;
        d.link      = cif.link;
        d.mem_read  = cif.mem_read;
        d.mem_write = cif.mem_write;
        d.illegal   = cif.illegal;
        d.z_ok      = cif.z_ok;
        return d;
    endfunction

    // Expected values every instruction shares before its own overrides
    function automatic dec_t dflt(input logic [31:0] ins);
        dec_t d;
        d        = '0;
        d.addr_a = ins[25:21];
        d.addr_b = ins[20:16];
        d.imm16  = ins[15:0];
        d.addr26 = ins[25:0];
        return d;
    endfunction

    task automatic push(input string name, input logic [31:0] ins,
                        input logic az, input logic pulse, input dec_t e);
        sb_item_t it;
        it.name  = name;
        it.ins   = ins;
        it.az    = az;
        it.pulse = pulse;
        it.exp   = e;
        sb.push_back(it);
    endtask

    task automatic test_reset();
        sb_item_t it;
        dec_t e, got;
        e = dflt(32'h64000000);
`ifdef CONTROL_ZFLAG_EN
        e.is_branch = 1'b1; e.cond_sel = 2'b11; e.tgt_sel = 2'b01; e.z_ok = 1'b1;
`else
        e.illegal = 1'b1;
`endif
        push("reset_bn", 32'h64000000, 1'b1, 1'b0, e);
        reset = 1'b1;
        @(negedge clk);
        it = sb.pop_front();
        cif.instruction = it.ins;
        cif.alu_zero    = it.az;
        @(posedge clk);
        #2;
        got = sample();
        total++;
        if (got !== it.exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", it.name, got, it.exp);
        end else begin
            $display("ok   %s ins=%h", it.name, it.ins);
        end
        reset = 1'b0;
    endtask

    task automatic test_decode();
        sb_item_t it;
        dec_t e, got;
        e = dflt(32'h2010FEFE); e.addr_in = 16; e.alu_src = 1; e.reg_write = 1;
        push("addi", 32'h2010FEFE, 1'b0, 1'b0, e);
        e = dflt(32'h00108400); e.addr_a = 16; e.addr_in = 16; e.shamt = 16;
        e.alu_op = 3'd6; e.reg_write = 1;
        push("sll", 32'h00108400, 1'b0, 1'b0, e);
        e = dflt(32'h00004020); e.addr_in = 8; e.reg_write = 1;
        push("add", 32'h00004020, 1'b0, 1'b0, e);
        e = dflt(32'h0111482A); e.addr_in = 9; e.alu_op = 3'd5; e.reg_write = 1;
        push("slt", 32'h0111482A, 1'b0, 1'b0, e);
        e = dflt(32'h01094027); e.addr_in = 8; e.alu_op = 3'd4; e.reg_write = 1;
        push("nor", 32'h01094027, 1'b0, 1'b0, e);
        e = dflt(32'h3084FFFF); e.addr_in = 4; e.alu_op = 3'd2; e.alu_src = 1;
        e.imm_zext = 1; e.reg_write = 1;
        push("andi", 32'h3084FFFF, 1'b0, 1'b0, e);
        e = dflt(32'h8C880004); e.addr_in = 8; e.alu_src = 1; e.mem_read = 1;
        e.reg_write = 1;
        push("lw", 32'h8C880004, 1'b0, 1'b0, e);
        e = dflt(32'hAD100000); e.addr_a = 16; e.addr_b = 8; e.alu_src = 1;
        e.mem_write = 1;
        push("sw", 32'hAD100000, 1'b0, 1'b0, e);
        foreach (sb[i]) begin end
        while (sb.size() > 0) begin
            it = sb.pop_front();
            @(negedge clk);
            cif.instruction = it.ins;
            cif.alu_zero    = it.az;
            #2;
            got = sample();
            total++;
            if (got !== it.exp) begin
                bad++;
                $display("FAIL %s: got=%h want=%h", it.name, got, it.exp);
            end else begin
                $display("ok   %s ins=%h", it.name, it.ins);
            end
        end
    endtask

    task automatic test_branch_jump();
        sb_item_t it;
        dec_t e, got;
        e = dflt(32'h1520FFFD); e.is_branch = 1; e.cond_sel = 2'b10; e.alu_op = 3'd5;
        push("bne", 32'h1520FFFD, 1'b0, 1'b0, e);
        e = dflt(32'hB0220003); e.is_branch = 1; e.cond_sel = 2'b01; e.alu_op = 3'd5;
        e.link = 1; e.reg_write = 1; e.addr_in = 31;
        push("beqal", 32'hB0220003, 1'b0, 1'b0, e);
        e = dflt(32'h0C000010); e.is_jump = 1; e.tgt_sel = 2'b01; e.link = 1;
        e.reg_write = 1; e.addr_in = 31;
        push("jal", 32'h0C000010, 1'b0, 1'b0, e);
        e = dflt(32'h08000400); e.is_jump = 1; e.tgt_sel = 2'b01;
        push("j", 32'h08000400, 1'b0, 1'b0, e);
        e = dflt(32'h03E00008); e.is_jump = 1; e.tgt_sel = 2'b10;
        push("jr", 32'h03E00008, 1'b0, 1'b0, e);
        e = dflt(32'h0060F809); e.is_jump = 1; e.tgt_sel = 2'b10; e.link = 1;
        e.reg_write = 1; e.addr_in = 31;
        push("jalr", 32'h0060F809, 1'b0, 1'b0, e);
        e = dflt(32'h48A00010); e.is_jump = 1; e.tgt_sel = 2'b11; e.alu_src = 1;
        push("jm", 32'h48A00010, 1'b0, 1'b0, e);
        e = dflt(32'h7C050040); e.is_jump = 1; e.tgt_sel = 2'b00; e.link = 1;
        e.reg_write = 1; e.addr_in = 5;
        push("jalpc", 32'h7C050040, 1'b0, 1'b0, e);
        while (sb.size() > 0) begin
            it = sb.pop_front();
            @(negedge clk);
            cif.instruction = it.ins;
            cif.alu_zero    = it.az;
            #2;
            got = sample();
            total++;
            if (got !== it.exp) begin
                bad++;
                $display("FAIL %s: got=%h want=%h", it.name, got, it.exp);
            end else begin
                $display("ok   %s ins=%h", it.name, it.ins);
            end
        end
    endtask

    task automatic test_zflag();
        sb_item_t it;
        dec_t e, got;
`ifdef CONTROL_ZFLAG_EN
        e = dflt(32'h00000022); e.alu_op = 3'd1; e.reg_write = 1;
        push("sub_az1", 32'h00000022, 1'b1, 1'b0, e);
        e = dflt(32'h60000000); e.is_branch = 1; e.cond_sel = 2'b11; e.tgt_sel = 2'b01;
        e.z_ok = 1;
        push("bz_z1", 32'h60000000, 1'b0, 1'b0, e);
        e = dflt(32'h00000015); e.is_branch = 1; e.cond_sel = 2'b11; e.tgt_sel = 2'b10;
        push("brn_z1", 32'h00000015, 1'b0, 1'b0, e);
        e = dflt(32'h60000000); e.is_branch = 1; e.cond_sel = 2'b11; e.tgt_sel = 2'b01;
        push("bz_midreset", 32'h60000000, 1'b0, 1'b1, e);
        e = dflt(32'h8C880004); e.addr_in = 8; e.alu_src = 1; e.mem_read = 1;
        e.reg_write = 1;
        push("lw_az1", 32'h8C880004, 1'b1, 1'b0, e);
        e = dflt(32'h60000000); e.is_branch = 1; e.cond_sel = 2'b11; e.tgt_sel = 2'b01;
        push("bz_after_lw", 32'h60000000, 1'b0, 1'b0, e);
        e = dflt(32'h2010FEFE); e.addr_in = 16; e.alu_src = 1; e.reg_write = 1;
        push("addi_az1", 32'h2010FEFE, 1'b1, 1'b0, e);
        e = dflt(32'h6C000000); e.is_branch = 1; e.cond_sel = 2'b11; e.tgt_sel = 2'b01;
        e.link = 1; e.reg_write = 1; e.addr_in = 31;
        push("baln_z1", 32'h6C000000, 1'b0, 1'b0, e);
        e = dflt(32'h58030000); e.is_branch = 1; e.cond_sel = 2'b11; e.tgt_sel = 2'b11;
        e.alu_src = 1; e.link = 1; e.reg_write = 1; e.addr_in = 3; e.z_ok = 1;
        push("balmz_z1", 32'h58030000, 1'b0, 1'b0, e);
        e = dflt(32'h00003816); e.is_branch = 1; e.cond_sel = 2'b11; e.tgt_sel = 2'b10;
        e.link = 1; e.reg_write = 1; e.addr_in = 7; e.z_ok = 1;
        push("balrz_z1", 32'h00003816, 1'b0, 1'b0, e);
`else
        e = dflt(32'h60000000); e.illegal = 1;
        push("bz_off", 32'h60000000, 1'b1, 1'b0, e);
        e = dflt(32'h00000015); e.illegal = 1;
        push("brn_off", 32'h00000015, 1'b0, 1'b0, e);
        e = dflt(32'h58030000); e.illegal = 1;
        push("balmz_off", 32'h58030000, 1'b0, 1'b0, e);
        e = dflt(32'h00003816); e.illegal = 1;
        push("balrz_off", 32'h00003816, 1'b0, 1'b0, e);
`endif
        while (sb.size() > 0) begin
            it = sb.pop_front();
            @(negedge clk);
            cif.instruction = it.ins;
            cif.alu_zero    = it.az;
            if (it.pulse) begin
                #1 reset = 1'b1;
                #1;
            end else begin
                #2;
            end
            got = sample();
            total++;
            if (got !== it.exp) begin
                bad++;
                $display("FAIL %s: got=%h want=%h", it.name, got, it.exp);
            end else begin
                $display("ok   %s ins=%h az=%b", it.name, it.ins, it.az);
            end
            reset = 1'b0;
        end
    endtask

    task automatic test_illegal();
        sb_item_t it;
        dec_t e, got;
        e = dflt(32'hFC000000); e.illegal = 1;
        push("op3f", 32'hFC000000, 1'b0, 1'b0, e);
        e = dflt(32'h0000003F); e.illegal = 1;
        push("funct3f", 32'h0000003F, 1'b0, 1'b0, e);
        e = dflt(32'h04000000); e.illegal = 1;
        push("op01", 32'h04000000, 1'b0, 1'b0, e);
        while (sb.size() > 0) begin
            it = sb.pop_front();
            @(negedge clk);
            cif.instruction = it.ins;
            cif.alu_zero    = it.az;
            #2;
            got = sample();
            total++;
            if (got !== it.exp) begin
                bad++;
                $display("FAIL %s: got=%h want=%h", it.name, got, it.exp);
            end else begin
                $display("ok   %s ins=%h", it.name, it.ins);
            end
        end
    endtask

    task automatic test_back_to_back();
        sb_item_t it;
        dec_t e, got;
        logic [4:0] rs, rt, rd;
        logic [31:0] ins;
        for (int k = 0; k < 8; k++) begin
            rs  = 5'($urandom_range(0, 31));
            rt  = 5'($urandom_range(0, 31));
            rd  = 5'($urandom_range(0, 31));
            ins = {6'h00, rs, rt, rd, 5'd0, 6'h20};
            e = dflt(ins); e.addr_in = rd; e.reg_write = 1;
            push("b2b_add", ins, 1'b0, 1'b0, e);
        end
        while (sb.size() > 0) begin
            it = sb.pop_front();
            @(negedge clk);
            cif.instruction = it.ins;
            cif.alu_zero    = it.az;
            #2;
            got = sample();
            total++;
            if (got !== it.exp) begin
                bad++;
                $display("FAIL %s: got=%h want=%h", it.name, got, it.exp);
            end else begin
                $display("ok   %s ins=%h", it.name, it.ins);
            end
        end
    endtask

    initial begin
        reset           = 1'b0;
        cif.instruction = 32'h0;
        cif.alu_zero    = 1'b0;
        test_reset();
        test_decode();
        test_branch_jump();
        test_zflag();
        test_illegal();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
